// File: rtl/packet_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : packet_assembler_pkg
// Description : Shared definitions for the UART receive path and the packet
//               assembler: FSM state encodings, default packet width, and the
//               clock/baud figures the inter-byte timeout is derived from.
// Revision    : 1.0 - initial release
// ============================================================================
package packet_assembler_pkg;

  // Assembler FSM states. The encodings are fixed because the packet sender
  // on the TX side decodes the same values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int CLK_HZ              = 12_000_000;
  localparam int BAUD                = 115_200;
  localparam int DEFAULT_PACKET_SIZE = 32;
  // About 10 ms of silence between bytes ends a partial packet.
  localparam int DEFAULT_TIMEOUT_CYC = CLK_HZ / 100;

endpackage : packet_assembler_pkg
`default_nettype wire

// File: rtl/byte_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : byte_timeout_timer
// Description : Saturating cycle counter that flags when LIMIT-1 cycles have
//               elapsed since the last clear. Reusable as a TX watchdog.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_clear    - restart counting from zero (wins over i_enable)
//               i_enable   - count this cycle
//               o_expired  - counter sits at LIMIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module byte_timeout_timer #(
  parameter int LIMIT = 120_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            TW          = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [TW-1:0] c_last_tick = TW'(LIMIT - 1);

  logic [TW-1:0] r_count;

  // Stops at LIMIT-1 rather than wrapping, so expiry is sticky until cleared.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_last_tick)) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_expired = (r_count == c_last_tick);

endmodule : byte_timeout_timer
`default_nettype wire

// File: rtl/packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : packet_assembler
// Description : Assembles bytes from the UART receiver into a PACKET_SIZE-bit
//               packet (first byte in the LSB lane), holds it until the
//               consumer acknowledges, drops partial packets after an
//               inter-byte timeout and flags bytes lost while holding.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               rxbyte, rxvalid    - byte and one-cycle strobe from UART RX
//               pkt_ack            - consumer took buff (only used in HOLD)
//               buff               - assembled packet
//               pkt_valid          - buff holds a complete packet
//               busy               - partial packet in progress
//               timeout_err        - pulse: partial packet discarded
//               overrun_err        - pulse: byte dropped while holding
// Revision    : 1.0 - initial release
// ============================================================================
module packet_assembler
  import packet_assembler_pkg::*;
#(
  parameter int PACKET_SIZE = DEFAULT_PACKET_SIZE,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rxbyte,
  input  logic                   rxvalid,
  input  logic                   pkt_ack,
  output logic [PACKET_SIZE-1:0] buff,
  output logic                   pkt_valid,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  localparam int            NBYTES      = PACKET_SIZE / 8;
  localparam int            CW          = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] c_last_lane = CW'(NBYTES - 1);

  state_t                 r_state;
  logic [CW-1:0]          r_count;
  logic [PACKET_SIZE-1:0] r_buff;
  logic                   r_pkt_valid;
  logic                   r_busy;
  logic                   r_timeout_err;
  logic                   r_overrun_err;

  state_t                 w_state_next;
  logic [CW-1:0]          w_count_next;
  logic [PACKET_SIZE-1:0] w_buff_next;
  logic                   w_lane_we;
  logic [CW-1:0]          w_lane_idx;
  logic                   w_timeout_next;
  logic                   w_overrun_next;
  logic                   w_expired;
  logic                   w_timer_clear;
  logic                   w_timer_enable;

  // Timer only runs while a packet is partial; any accepted byte restarts it.
  assign w_timer_clear  = (r_state != ST_RECV) || rxvalid;
  assign w_timer_enable = (r_state == ST_RECV);

  byte_timeout_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_enable),
    .o_expired (w_expired)
  );

  // Next-state, counter and lane-write decode.
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_lane_we      = 1'b0;
    w_lane_idx     = '0;
    w_timeout_next = 1'b0;
    w_overrun_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (rxvalid) begin
          w_lane_we    = 1'b1;
          w_lane_idx   = '0;
          w_count_next = CW'(1);
          w_state_next = (NBYTES == 1) ? ST_HOLD : ST_RECV;
        end
      end
      ST_RECV: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rxvalid) begin
          w_lane_we    = 1'b1;
          w_lane_idx   = r_count;
          w_count_next = r_count + CW'(1);
          if (r_count == c_last_lane) begin
            w_state_next = ST_HOLD;
          end
        end else if (w_expired) begin
          w_timeout_next = 1'b1;
          w_count_next   = '0;
          w_state_next   = ST_IDLE;
        end
      end
      ST_HOLD: begin
        w_overrun_next = rxvalid;
        if (pkt_ack) begin
          w_count_next = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_count_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase

    // Timed-out packets leave their stale bytes in place; pkt_valid gates them.
    w_buff_next = r_buff;
    if (w_lane_we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (w_lane_idx == CW'(k)) begin
          w_buff_next[8*k +: 8] = rxbyte;
        end
      end
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_buff        <= '0;
      r_pkt_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_count       <= w_count_next;
      r_buff        <= w_buff_next;
      r_pkt_valid   <= (w_state_next == ST_HOLD);
      r_busy        <= (w_state_next == ST_RECV);
      r_timeout_err <= w_timeout_next;
      r_overrun_err <= w_overrun_next;
    end
  end

  assign buff        = r_buff;
  assign pkt_valid   = r_pkt_valid;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule : packet_assembler
`default_nettype wire

// File: tb/tb_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_assembler
// Description : Self-checking bench for packet_assembler. A 32-bit instance
//               (short timeout) and an 8-bit instance run side by side;
//               expected packets are queued when their bytes are driven and
//               popped when the assembler presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_assembler;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxbyte,  rxbyte8;
  logic        rxvalid, rxvalid8;
  logic        pkt_ack, pkt_ack8;
  logic [31:0] buff;
  logic        pkt_valid, busy, timeout_err, overrun_err;
  logic [7:0]  buff8;
  logic        pkt_valid8, busy8, timeout_err8, overrun_err8;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] q32[$];
  logic [7:0]  q8[$];

  always #5 clk = ~clk;

  packet_assembler #(.PACKET_SIZE(32), .TIMEOUT_CYC(TO)) dut32 (
    .clk(clk), .rst(rst), .rxbyte(rxbyte), .rxvalid(rxvalid), .pkt_ack(pkt_ack),
    .buff(buff), .pkt_valid(pkt_valid), .busy(busy),
    .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  packet_assembler #(.PACKET_SIZE(8), .TIMEOUT_CYC(TO)) dut8 (
    .clk(clk), .rst(rst), .rxbyte(rxbyte8), .rxvalid(rxvalid8), .pkt_ack(pkt_ack8),
    .buff(buff8), .pkt_valid(pkt_valid8), .busy(busy8),
    .timeout_err(timeout_err8), .overrun_err(overrun_err8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send32(input logic [7:0] b);
    rxbyte  = b;
    rxvalid = 1'b1;
    tick();
    rxvalid = 1'b0;
  endtask

  task automatic send_packet32(input logic [31:0] p, input int gap);
    q32.push_back(p);
    for (int i = 0; i < 4; i++) begin
      send32(p[8*i +: 8]);
      if (i < 3) idle(gap);
    end
  endtask

  // Called right after the last byte: pkt_valid must already be high.
  task automatic expect_pkt32(input string name);
    logic [31:0] e;
    n_tests++;
    if (q32.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected packet queued, buff=%h", name, buff);
    end else begin
      e = q32.pop_front();
      if (pkt_valid !== 1'b1 || buff !== e) begin
        n_fail++;
        $display("FAIL %s: pkt_valid=%b buff=%h, required pkt_valid=1 buff=%h",
                 name, pkt_valid, buff, e);
      end
    end
  endtask

  task automatic ack32(input string name);
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    n_tests++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: pkt_valid=%b busy=%b after ack, required 0 0",
               name, pkt_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    n_tests++;
    if (buff !== 32'h0 || pkt_valid !== 1'b0 || busy !== 1'b0 ||
        timeout_err !== 1'b0 || overrun_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset32: buff=%h pv=%b busy=%b to=%b ov=%b, required all 0",
               buff, pkt_valid, busy, timeout_err, overrun_err);
    end
    n_tests++;
    if (buff8 !== 8'h0 || pkt_valid8 !== 1'b0 || busy8 !== 1'b0 ||
        timeout_err8 !== 1'b0 || overrun_err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: buff=%h pv=%b busy=%b to=%b ov=%b, required all 0",
               buff8, pkt_valid8, busy8, timeout_err8, overrun_err8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    q32.push_back(32'h44332211);
    send32(8'h11);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_recv: busy=%b, required 1", busy);
    end
    idle(1); send32(8'h22);
    idle(1); send32(8'h33);
    n_tests++;
    if (pkt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_valid: pkt_valid=%b after 3 bytes, required 0", pkt_valid);
    end
    idle(1); send32(8'h44);
    expect_pkt32("basic_pkt");
  endtask

  task automatic test_overrun();
    send32(8'h55);
    n_tests++;
    if (overrun_err !== 1'b1 || pkt_valid !== 1'b1 || buff !== 32'h44332211) begin
      n_fail++;
      $display("FAIL overrun_pulse: ov=%b pv=%b buff=%h, required 1 1 44332211",
               overrun_err, pkt_valid, buff);
    end
    idle(1);
    n_tests++;
    if (overrun_err !== 1'b0 || buff !== 32'h44332211) begin
      n_fail++;
      $display("FAIL overrun_width: ov=%b buff=%h, required 0 44332211", overrun_err, buff);
    end
    ack32("overrun_ack");
    send_packet32(32'hDEADBEEF, 0);
    expect_pkt32("after_ack_pkt");
    ack32("after_ack_ack");
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    send32(8'h01);
    send32(8'h02);
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO && timeout_err !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (early !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse: early=%b to=%b busy=%b, required 0 1 0",
               early, timeout_err, busy);
    end
    idle(1);
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_width: to=%b, required 0", timeout_err);
    end
    send_packet32(32'hA3A2A1A0, 1);
    expect_pkt32("post_timeout_pkt");
    ack32("post_timeout_ack");
  endtask

  task automatic test_timeout_boundary();
    q32.push_back(32'h0C0B0A09);
    send32(8'h09);
    send32(8'h0A);
    idle(TO - 1);
    send32(8'h0B);
    n_tests++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_byte: to=%b busy=%b, required 0 1", timeout_err, busy);
    end
    send32(8'h0C);
    expect_pkt32("boundary_pkt");
    ack32("boundary_ack");
  endtask

  task automatic test_reset_mid();
    send32(8'h21);
    send32(8'h22);
    rst = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0 || buff !== 32'h0 || pkt_valid !== 1'b0 ||
        timeout_err !== 1'b0 || overrun_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b buff=%h pv=%b to=%b ov=%b, required 0 0 0 0 0",
               busy, buff, pkt_valid, timeout_err, overrun_err);
    end
    rst = 1'b0;
    tick();
    send_packet32(32'h87654321, 2);
    expect_pkt32("post_reset_pkt");
    ack32("post_reset_ack");
  endtask

  task automatic test_single_byte();
    logic        busy_seen = 1'b0;
    logic [7:0]  e;
    q8.push_back(8'h7E);
    rxbyte8 = 8'h7E; rxvalid8 = 1'b1;
    tick();
    rxvalid8 = 1'b0;
    if (busy8 !== 1'b0) busy_seen = 1'b1;
    e = q8.pop_front();
    n_tests++;
    if (pkt_valid8 !== 1'b1 || buff8 !== e) begin
      n_fail++;
      $display("FAIL byte8_pkt: pv=%b buff=%h, required 1 %h", pkt_valid8, buff8, e);
    end
    // Same-cycle byte and ack: byte dropped with overrun, then back to IDLE.
    rxbyte8 = 8'h99; rxvalid8 = 1'b1; pkt_ack8 = 1'b1;
    tick();
    rxvalid8 = 1'b0; pkt_ack8 = 1'b0;
    if (busy8 !== 1'b0) busy_seen = 1'b1;
    n_tests++;
    if (overrun_err8 !== 1'b1 || pkt_valid8 !== 1'b0 || buff8 !== 8'h7E) begin
      n_fail++;
      $display("FAIL byte8_ack_overrun: ov=%b pv=%b buff=%h, required 1 0 7e",
               overrun_err8, pkt_valid8, buff8);
    end
    idle(1);
    n_tests++;
    if (overrun_err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL byte8_overrun_width: ov=%b, required 0", overrun_err8);
    end
    q8.push_back(8'h3C);
    rxbyte8 = 8'h3C; rxvalid8 = 1'b1;
    tick();
    rxvalid8 = 1'b0;
    if (busy8 !== 1'b0) busy_seen = 1'b1;
    e = q8.pop_front();
    n_tests++;
    if (pkt_valid8 !== 1'b1 || buff8 !== e) begin
      n_fail++;
      $display("FAIL byte8_second_pkt: pv=%b buff=%h, required 1 %h", pkt_valid8, buff8, e);
    end
    pkt_ack8 = 1'b1;
    tick();
    pkt_ack8 = 1'b0;
    n_tests++;
    if (busy_seen !== 1'b0 || pkt_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL byte8_busy_never: busy_seen=%b pv=%b, required 0 0", busy_seen, pkt_valid8);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rxbyte   = 8'h0; rxvalid  = 1'b0; pkt_ack  = 1'b0;
    rxbyte8  = 8'h0; rxvalid8 = 1'b0; pkt_ack8 = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_single_byte();
    n_tests++;
    if (q32.size() != 0 || q8.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d/%0d packets never checked, required 0/0",
               q32.size(), q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_packet_assembler
`default_nettype wire
